// File: rtl/quad_phase_gen.sv
// Two-phase (A/B) quadrature pattern generator: emits a programmable number of
// Gray-coded phase edges at a programmable period, in either direction.
module quad_phase_gen #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  input  logic             abort,
  output logic             ph_a,
  output logic             ph_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state_q;
  logic [1:0]       q_q;
  logic [1:0]       q_d;
  logic             dir_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] pos_d;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] div_q;
  logic             fin_wait_q;
  logic             ph_a_q;
  logic             ph_b_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    q_d   = dir_q ? (q_q + 2'd1) : (q_q - 2'd1);
    pos_d = pos_q + CNT_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      q_q        <= '0;
      dir_q      <= 1'b0;
      steps_q    <= '0;
      pos_q      <= '0;
      period_q   <= '0;
      div_q      <= '0;
      fin_wait_q <= 1'b0;
      ph_a_q     <= 1'b0;
      ph_b_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (steps != '0 && period != '0) begin
              dir_q    <= dir;
              steps_q  <= steps;
              period_q <= period;
              pos_q    <= '0;
              div_q    <= period - DIV_W'(1);
              busy_q   <= 1'b1;
              state_q  <= RUN;
            end else begin
              // Empty command: one extra FIN cycle so done lands two clocks after start.
              fin_wait_q <= 1'b1;
              state_q    <= FIN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (div_q == '0) begin
            q_q    <= q_d;
            ph_a_q <= q_d[0] ^ q_d[1];
            ph_b_q <= q_d[1];
            pos_q  <= pos_d;
            div_q  <= period_q - DIV_W'(1);
            if (pos_d == steps_q) begin
              state_q <= FIN;
            end
          end else begin
            div_q <= div_q - DIV_W'(1);
          end
        end
        FIN: begin
          if (fin_wait_q) begin
            fin_wait_q <= 1'b0;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ph_a = ph_a_q;
  assign ph_b = ph_b_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pos  = pos_q;

endmodule

// File: tb/tb_quad_phase_gen.sv
// Scoreboard bench for quad_phase_gen: per-cycle expectations derived from
// closed-form edge timing are queued at command issue and popped each clock.
module tb_quad_phase_gen;

  localparam int CNT_W = 8;
  localparam int DIV_W = 16;
  localparam int VW    = 4 + CNT_W;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             start   = 1'b0;
  logic             dir     = 1'b0;
  logic [CNT_W-1:0] steps   = '0;
  logic [DIV_W-1:0] period  = '0;
  logic             abort   = 1'b0;
  logic             ph_a;
  logic             ph_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pos;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          q_model = 0;
  int          pos_model = 0;
  logic [VW-1:0] exp_q[$];

  quad_phase_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .start  (start),
    .dir    (dir),
    .steps  (steps),
    .period (period),
    .abort  (abort),
    .ph_a   (ph_a),
    .ph_b   (ph_b),
    .busy   (busy),
    .done   (done),
    .pos    (pos)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ph_of(input int q);
    case (q)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int qmove(input int q0, input bit d, input int k);
    return d ? ((q0 + k) % 4) : ((q0 - (k % 4) + 4) % 4);
  endfunction

  function automatic logic [VW-1:0] snap();
    return {ph_a, ph_b, busy, done, pos};
  endfunction

  // Issue one command at edge T and check ncyc clocks after it.
  // abort_n/restart_n/rst_n: cycle index (after T) at whose edge that event is sampled; 0 = none.
  task automatic run_cmd(input string tag, input bit d, input int st, input int per,
                         input int ncyc, input int abort_n, input int restart_n, input int rst_n);
    int total;
    bit zero;
    int k, qn, p;
    bit b, dn;
    logic [1:0] prev_ph, cur_ph;
    logic [VW-1:0] e;
    total = st * per;
    zero  = (st == 0) || (per == 0);
    qn = q_model;
    p  = pos_model;
    for (int n = 1; n <= ncyc; n++) begin
      if (rst_n != 0 && n >= rst_n) begin
        qn = 0; b = 0; dn = 0; p = 0;
      end else if (zero) begin
        qn = q_model; b = 0; dn = (n == 2); p = pos_model;
      end else if (abort_n != 0 && n >= abort_n) begin
        k = (abort_n - 1) / per;
        qn = qmove(q_model, d, k); b = 0; dn = 0; p = k;
      end else begin
        k = (n >= total) ? st : n / per;
        qn = qmove(q_model, d, k); b = (n <= total); dn = (n == total + 1); p = k;
      end
      exp_q.push_back({ph_of(qn), b, dn, CNT_W'(p)});
    end
    q_model   = qn;
    pos_model = p;

    @(negedge sys_clk);
    dir = d; steps = CNT_W'(st); period = DIV_W'(per); start = 1'b1; abort = 1'b0;
    prev_ph = {ph_a, ph_b};
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge sys_clk);
      start   = 1'b0;
      abort   = (n == abort_n);
      sys_rst = (rst_n != 0) && (n == rst_n);
      if (n == restart_n) begin
        start = 1'b1; dir = ~d; steps = 8'd1; period = 16'd1;
      end
      @(posedge sys_clk);
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("%s[%0d]", tag, n), 32'(snap()), 32'(e));
      cur_ph = {ph_a, ph_b};
      if (n != rst_n)
        check_eq($sformatf("%s/gray[%0d]", tag, n), 32'($countones(cur_ph ^ prev_ph) <= 1), 32'd1);
      prev_ph = cur_ph;
    end
    @(negedge sys_clk);
    start = 1'b0; abort = 1'b0; sys_rst = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] e;
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("reset", 32'(snap()), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) exp_q.push_back('0);
    for (int i = 0; i < 20; i++) begin
      @(posedge sys_clk);
      #1;
      e = exp_q.pop_front();
      check_eq($sformatf("idle[%0d]", i), 32'(snap()), 32'(e));
    end

    run_cmd("fwd4x4",  1'b1, 4,  4, 20, 0, 0, 0);
    run_cmd("fwd1x1",  1'b1, 1,  1,  4, 0, 0, 0);
    run_cmd("rev3x2",  1'b0, 3,  2,  9, 0, 0, 0);
    run_cmd("abort",   1'b1, 10, 3, 12, 7, 0, 0);
    run_cmd("steps0",  1'b1, 0,  5,  5, 0, 0, 0);
    run_cmd("period0", 1'b0, 3,  0,  5, 0, 0, 0);
    run_cmd("restart", 1'b1, 3,  2, 10, 0, 3, 0);
    run_cmd("midrst",  1'b1, 8,  2,  8, 0, 0, 5);
    run_cmd("fresh",   1'b1, 2,  1,  5, 0, 0, 0);

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_phase_gen.md
Name: quad_phase_gen

Overview:
- Two-phase (A/B) quadrature pattern generator. It is the transmit side of the two-input rotation/direction detector.
- Drives the detector's two sensor inputs with a Gray-coded step sequence.
- Step count, direction and step period are programmable, and each command reports completion.
- Used as a stimulus source on the board and for closed-loop checking of the detector.

Parameters:
- CNT_W, 8: width of step count and position counter.
- DIV_W, 16: width of the step-period divider.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle command strobe, sampled only in IDLE.
- dir  input  1  1 = forward, 0 = reverse; latched on accepted start.
- steps  input  CNT_W  number of phase edges to emit; latched on accepted start.
- period  input  DIV_W  clocks per edge; latched on accepted start.
- abort  input  1  stop the current command.
- ph_a  output  1  phase A (detector "in").
- ph_b  output  1  phase B (detector "in1").
- busy  output  1  high while a command runs.
- done  output  1  one-cycle pulse when a command completes normally.
- pos  output  CNT_W  edges emitted in the current/last command.

Behaviour:
- Reset (sys_rst=1 at a clock edge): all of the following are cleared; reset overrides every other input, including mid-command.
  - state = IDLE
  - phase index q = 0, so ph_a = 0, ph_b = 0
  - busy = 0, done = 0, pos = 0
  - divider = 0
- Phase mapping, registered outputs (ph_a, ph_b):
  - q=0 → (0,0)
  - q=1 → (1,0)
  - q=2 → (1,1)
  - q=3 → (0,1)
- Edge update:
  - Forward: q ← q+1 mod 4. Reverse: q ← q−1 mod 4.
  - Exactly one output bit changes per edge.
  - q is NOT cleared by start, so consecutive commands continue the sequence seamlessly.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 and abort=0, with steps≠0 and period≠0 (start sampled at edge T):
    - latch dir/steps/period
    - pos ← 0, divider ← period−1, busy ← 1
    - go to RUN
  - start=1 with steps=0 or period=0: no edges; go to FIN (done pulses at T+2, busy stays 0).
  - start and abort in the same cycle: abort wins, command ignored.
- RUN, each clock:
  - abort=1: go to IDLE. busy ← 0, no done, ph_a/ph_b/pos hold their current values.
  - else if divider=0: advance q, pos ← pos+1, divider ← period−1. If pos+1 = steps, go to FIN.
  - else divider ← divider−1.
- RUN timing:
  - Edge k (1..steps) is visible on ph_a/ph_b after clock T + k·period.
  - period=1 gives one edge per clock.
- FIN: done ← 1 and busy ← 0 for exactly one cycle (visible after T + steps·period + 1), then IDLE.
- start while busy or in FIN: ignored, no queueing.
- pos holds its final value until the next accepted start.
- Latched parameters are immune to input changes during RUN.
- pos never wraps within a command (pos ≤ steps ≤ 2^CNT_W−1).
- divider arithmetic is unsigned DIV_W bits.
- No combinational input-to-output paths.

Test Plan:
- Reset then idle: sys_rst held 3 clocks → ph_a=0, ph_b=0, busy=0, done=0, pos=0 and stable for 20 clocks.
- Forward, steps=4, period=4, start at T → (ph_a,ph_b) = 10@T+4, 11@T+8, 01@T+12, 00@T+16; busy=1 over T+1..T+16; done=1 only at T+17; pos=4.
- Reverse continuation: after forward steps=1 period=1 (q=1), issue reverse steps=3 period=2 → 00, 01, 11 at +2/+4/+6; done one cycle later; each transition changes exactly one bit.
- Abort: forward steps=10, period=3, abort asserted at T+7 → two edges emitted, pos=2, busy=0 next cycle, done never asserted, outputs hold.
- Zero cases and ignored start:
  - steps=0 → done pulse at T+2, no output change, busy never 1.
  - A second start during RUN → has no effect on step count or timing.
- Reset mid-RUN (steps=8, period=2, sys_rst at T+5) → next cycle all outputs 0, state IDLE; a new start behaves as from power-on.
